// File: rtl/mul_div_unit_if.sv
// Request/result bundle for the iterative signed multiply/divide unit.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, z_hi, z_lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, z_hi, z_lo, div_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / signed divide (non-restoring on
// magnitudes), one iteration per clock, WIDTH iterations per operation.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           clr,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int HW = WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    iterCnt_q, iterCnt_d;
    logic [HW-1:0]    hiAcc_q, hiAcc_d;
    logic [WIDTH-1:0] loAcc_q, loAcc_d;
    logic             booth_q, booth_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] aRaw_q, aRaw_d;
    logic             op_q, op_d;
    logic             quotNeg_q, quotNeg_d;
    logic             remNeg_q, remNeg_d;
    logic [WIDTH-1:0] zHi_q, zHi_d;
    logic [WIDTH-1:0] zLo_q, zLo_d;
    logic             divZero_q, divZero_d;

    logic [WIDTH-1:0] aMag, bMag;
    logic [HW-1:0]    opndExt;
    logic [HW-1:0]    mulSum, mulHi, divShift, divR, divRFix;
    logic [WIDTH-1:0] mulLo, divLo, quotSigned, remSigned;

    // One iteration step of each algorithm plus final sign fix-up of the divide.
    always_comb begin
        aMag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
        bMag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
        opndExt  = op_q ? {2'b00, opnd_q} : {{2{opnd_q[WIDTH-1]}}, opnd_q};
        mulSum   = hiAcc_q;
        case ({loAcc_q[0], booth_q})
            2'b01:   mulSum = hiAcc_q + opndExt;
            2'b10:   mulSum = hiAcc_q - opndExt;
            default: mulSum = hiAcc_q;
        endcase
        mulHi    = {mulSum[HW-1], mulSum[HW-1:1]};
        mulLo    = {mulSum[0], loAcc_q[WIDTH-1:1]};
        divShift = {hiAcc_q[HW-2:0], loAcc_q[WIDTH-1]};
        divR     = hiAcc_q[HW-1] ? divShift + opndExt : divShift - opndExt;
        divLo    = {loAcc_q[WIDTH-2:0], ~divR[HW-1]};
        divRFix  = divR[HW-1] ? divR + opndExt : divR;
        quotSigned = quotNeg_q ? -divLo : divLo;
        remSigned  = remNeg_q ? -divRFix[WIDTH-1:0] : divRFix[WIDTH-1:0];
    end

    // Next-state and datapath update; a divide by zero uses its single RUN
    // cycle only to land DONE on the edge after the start edge, with no iteration.
    always_comb begin
        state_d   = state_q;
        iterCnt_d = iterCnt_q;
        hiAcc_d   = hiAcc_q;
        loAcc_d   = loAcc_q;
        booth_d   = booth_q;
        opnd_d    = opnd_q;
        aRaw_d    = aRaw_q;
        op_d      = op_q;
        quotNeg_d = quotNeg_q;
        remNeg_d  = remNeg_q;
        zHi_d     = zHi_q;
        zLo_d     = zLo_q;
        divZero_d = divZero_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    iterCnt_d = '0;
                    hiAcc_d   = '0;
                    booth_d   = 1'b0;
                    op_d      = bus.op;
                    aRaw_d    = bus.a;
                    quotNeg_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    remNeg_d  = bus.a[WIDTH-1];
                    if (bus.op) begin
                        loAcc_d = aMag;
                        opnd_d  = bMag;
                    end else begin
                        loAcc_d = bus.b;
                        opnd_d  = bus.a;
                    end
                end
            end
            RUN: begin
                if (op_q && (opnd_q == '0)) begin
                    state_d   = DONE;
                    zHi_d     = aRaw_q;
                    zLo_d     = '1;
                    divZero_d = 1'b1;
                end else begin
                    iterCnt_d = iterCnt_q + CW'(1);
                    if (op_q) begin
                        hiAcc_d = divR;
                        loAcc_d = divLo;
                    end else begin
                        hiAcc_d = mulHi;
                        loAcc_d = mulLo;
                        booth_d = loAcc_q[0];
                    end
                    if (iterCnt_q == LAST) begin
                        state_d   = DONE;
                        divZero_d = 1'b0;
                        zHi_d     = op_q ? remSigned : mulHi[WIDTH-1:0];
                        zLo_d     = op_q ? quotSigned : mulLo;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously while clr is low.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            iterCnt_q <= '0;
            hiAcc_q   <= '0;
            loAcc_q   <= '0;
            booth_q   <= 1'b0;
            opnd_q    <= '0;
            aRaw_q    <= '0;
            op_q      <= 1'b0;
            quotNeg_q <= 1'b0;
            remNeg_q  <= 1'b0;
            zHi_q     <= '0;
            zLo_q     <= '0;
            divZero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            iterCnt_q <= iterCnt_d;
            hiAcc_q   <= hiAcc_d;
            loAcc_q   <= loAcc_d;
            booth_q   <= booth_d;
            opnd_q    <= opnd_d;
            aRaw_q    <= aRaw_d;
            op_q      <= op_d;
            quotNeg_q <= quotNeg_d;
            remNeg_q  <= remNeg_d;
            zHi_q     <= zHi_d;
            zLo_q     <= zLo_d;
            divZero_q <= divZero_d;
        end
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.z_hi     = zHi_q;
    assign bus.z_lo     = zLo_q;
    assign bus.div_zero = divZero_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed corner cases plus random operations checked
// against plain 64-bit arithmetic.
module tb_mul_div_unit;
    localparam int WIDTH   = 32;
    localparam int MAXWAIT = 60;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    logic        rOp;
    logic [31:0] rA, rB, rHi, rLo;
    logic        rDz;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void refModel(input logic opV, input logic [31:0] aV, input logic [31:0] bV,
                                     output logic [31:0] hiV, output logic [31:0] loV, output logic dzV);
        longint sa, sb, prod, q, r;
        sa = longint'($signed(aV));
        sb = longint'($signed(bV));
        dzV = 1'b0;
        if (!opV) begin
            prod = sa * sb;
            hiV  = prod[63:32];
            loV  = prod[31:0];
        end else if (bV == 32'd0) begin
            hiV = aV;
            loV = 32'hFFFF_FFFF;
            dzV = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            hiV = r[31:0];
            loV = q[31:0];
        end
    endfunction

    task automatic applyStimulus(input string name, input logic opV, input logic [31:0] aV, input logic [31:0] bV,
                                 input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz,
                                 input int disturbAt, input int abortAt);
        int expLat;
        int cyc;
        expLat = (opV && bV == 32'd0) ? 1 : WIDTH;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = opV;
        bus.a     = aV;
        bus.b     = bV;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = ~opV;
        bus.a     = $urandom;
        bus.b     = $urandom;
        cyc = 0;
        while (cyc < MAXWAIT) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
            checkOutput({name, " busy/done exclusive"}, 64'(bus.busy & bus.done), 64'd0);
            if (cyc == disturbAt) begin
                bus.start = 1'b1;
                bus.op    = ~opV;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            if (cyc == abortAt) begin
                clr = 1'b0;
                #1;
                checkOutput({name, " abort z_hi"}, 64'(bus.z_hi), 64'd0);
                checkOutput({name, " abort z_lo"}, 64'(bus.z_lo), 64'd0);
                checkOutput({name, " abort div_zero"}, 64'(bus.div_zero), 64'd0);
                checkOutput({name, " abort busy"}, 64'(bus.busy), 64'd0);
                checkOutput({name, " abort done"}, 64'(bus.done), 64'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    checkOutput({name, " no done in reset"}, 64'(bus.done), 64'd0);
                end
                @(negedge clk);
                clr = 1'b1;
                return;
            end
            if (bus.done) break;
        end
        checkOutput({name, " latency"}, 64'(cyc), 64'(expLat));
        checkOutput({name, " z_hi"}, 64'(bus.z_hi), 64'(expHi));
        checkOutput({name, " z_lo"}, 64'(bus.z_lo), 64'(expLo));
        checkOutput({name, " div_zero"}, 64'(bus.div_zero), 64'(expDz));
        @(posedge clk); #1;
        checkOutput({name, " done one cycle"}, 64'(bus.done), 64'd0);
        checkOutput({name, " z_lo held"}, 64'(bus.z_lo), 64'(expLo));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        clr       = 1'b1;
        #2 clr = 1'b0;
        #1;
        checkOutput("reset z_hi", 64'(bus.z_hi), 64'd0);
        checkOutput("reset z_lo", 64'(bus.z_lo), 64'd0);
        checkOutput("reset div_zero", 64'(bus.div_zero), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;

        applyStimulus("mul 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        applyStimulus("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 0, 0);
        applyStimulus("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, 0);
        applyStimulus("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        applyStimulus("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0, 0);
        applyStimulus("div 5/0", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0, 0);
        applyStimulus("mul 6*7 after div0", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 0, 0);

        refModel(1'b0, 32'd12345, 32'hFFFF_FD5A, rHi, rLo, rDz);
        applyStimulus("mul disturbed", 1'b0, 32'd12345, 32'hFFFF_FD5A, rHi, rLo, rDz, 10, 0);

        applyStimulus("mul aborted", 1'b0, 32'h0000_1234, 32'h0000_5678, 32'd0, 32'd0, 1'b0, 0, 15);
        applyStimulus("mul 3*4 after reset", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            rOp = 1'($urandom_range(0, 1));
            rA  = $urandom;
            case ($urandom_range(0, 4))
                0:       rB = 32'd0;
                1:       rB = 32'($urandom_range(1, 9));
                2:       rB = -32'($urandom_range(1, 9));
                default: rB = $urandom;
            endcase
            refModel(rOp, rA, rB, rHi, rLo, rDz);
            applyStimulus(rOp ? "rand div" : "rand mul", rOp, rA, rB, rHi, rLo, rDz, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
